// File: rtl/axis_frame_checker.sv
// rtl/axis_frame_checker.sv - AXI-Stream result checker against golden BRAM with tready stall pattern
// Optional macro AXIS_FRAME_CHK_KEEP_MASK_EN: compare only bytes whose tkeep bit is set.
module axis_frame_checker #(
    parameter int DATA_WIDTH     = 64,
    parameter int FRAME_BEATS    = 256,
    parameter int GOLD_DEPTH     = 512,
    parameter int ADDR_W         = 9,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int STALL_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_gold_we,
    input  logic [ADDR_W-1:0]       i_gold_addr,
    input  logic [DATA_WIDTH-1:0]   i_gold_wdata,
    input  logic                    i_arm,
    input  logic [STALL_W-1:0]      i_stall_mask,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic [CNT_W-1:0]        o_err_cnt,
    output logic [CNT_W-1:0]        o_beat_cnt,
    output logic [CNT_W-1:0]        o_first_err_idx,
    output logic                    o_tlast_err,
    output logic                    o_timeout
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PH_W   = (STALL_W > 1) ? $clog2(STALL_W) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(FRAME_BEATS - 1);
    localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_BEATS);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(STALL_W - 1);
    localparam logic [ADDR_W:0]   GOLD_LIM   = (ADDR_W+1)'(GOLD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] gold_mem [GOLD_DEPTH];
    logic [DATA_WIDTH-1:0] gold_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [KEEP_W-1:0]     keep_q;
    logic [CNT_W-1:0]      idx_q;
    logic                  cmp_vld;
    logic [PH_W-1:0]       phase;
    logic [STALL_W-1:0]    mask_q;
    logic [IDLE_W-1:0]     idle_cnt;

    logic hs;
    logic arm_go;
    logic at_last;
    logic early_last;
    logic missing_last;
    logic frame_end;
    logic timeout_hit;
    logic gold_wr;
    logic mismatch;

    // Mask is registered so a change applies from the following cycle
    assign s_axis_tready = (state == S_RUN) & ~mask_q[phase];
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign arm_go        = i_arm & ((state == S_IDLE) | (state == S_DONE));
    assign at_last       = (o_beat_cnt == LAST_IDX);
    assign early_last    = hs & s_axis_tlast & (o_beat_cnt < LAST_IDX);
    assign missing_last  = hs & at_last & ~s_axis_tlast;
    assign frame_end     = hs & (s_axis_tlast | at_last);
    // A handshake on the would-be timeout cycle wins
    assign timeout_hit   = (state == S_RUN) & ~hs & (idle_cnt == IDLE_LIMIT);
    assign gold_wr       = i_gold_we & ~o_busy & ({1'b0, i_gold_addr} < GOLD_LIM);

    assign o_busy = (state == S_RUN) | (state == S_FLUSH);
    assign o_done = (state == S_DONE);
    assign o_pass = o_done & (o_err_cnt == '0) & ~o_tlast_err & ~o_timeout
                    & (o_beat_cnt == FRAME_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; FLUSH lasts one cycle so the final compare retires
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_arm) state_nx = S_RUN;
            S_RUN:   if (frame_end || timeout_hit) state_nx = S_FLUSH;
            S_FLUSH: state_nx = S_DONE;
            S_DONE:  if (i_arm) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // Golden BRAM: write port when not busy, read on each accepted beat
    always_ff @(posedge clk) begin
        if (gold_wr) begin
            gold_mem[i_gold_addr] <= i_gold_wdata;
        end
        if (hs) begin
            gold_q <= gold_mem[o_beat_cnt[ADDR_W-1:0]];
        end
    end

    // Stall mask capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= i_stall_mask;
        end
    end

    // Compare stage capture of the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            keep_q  <= '0;
            idx_q   <= '0;
            cmp_vld <= 1'b0;
        end else begin
            cmp_vld <= hs;
            if (hs) begin
                data_q <= s_axis_tdata;
                keep_q <= s_axis_tkeep;
                idx_q  <= o_beat_cnt;
            end
        end
    end

    // Beat mismatch decision
    always_comb begin
        mismatch = 1'b0;
`ifdef AXIS_FRAME_CHK_KEEP_MASK_EN
        for (int b = 0; b < KEEP_W; b++) begin
            if (keep_q[b] && (data_q[8*b +: 8] != gold_q[8*b +: 8])) begin
                mismatch = 1'b1;
            end
        end
`else
        mismatch = (data_q != gold_q) || (keep_q != {KEEP_W{1'b1}});
`endif
    end

    // Counters, flags, stall phase and inactivity counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err_cnt       <= '0;
            o_beat_cnt      <= '0;
            o_first_err_idx <= '1;
            o_tlast_err     <= 1'b0;
            o_timeout       <= 1'b0;
            idle_cnt        <= '0;
            phase           <= '0;
        end else if (arm_go) begin
            o_err_cnt       <= '0;
            o_beat_cnt      <= '0;
            o_first_err_idx <= '1;
            o_tlast_err     <= 1'b0;
            o_timeout       <= 1'b0;
            idle_cnt        <= '0;
            phase           <= '0;
        end else begin
            if (state == S_RUN) begin
                phase    <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
                idle_cnt <= hs ? '0 : idle_cnt + IDLE_W'(1);
            end
            if (hs && (o_beat_cnt != CNT_MAX)) begin
                o_beat_cnt <= o_beat_cnt + CNT_W'(1);
            end
            if (early_last || missing_last) begin
                o_tlast_err <= 1'b1;
            end
            if (timeout_hit) begin
                o_timeout <= 1'b1;
            end
            if (cmp_vld && mismatch) begin
                if (o_err_cnt != CNT_MAX) begin
                    o_err_cnt <= o_err_cnt + CNT_W'(1);
                end
                if (o_first_err_idx == CNT_MAX) begin
                    o_first_err_idx <= idx_q;
                end
            end
        end
    end

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- Synthesizable, parametrised AXI-Stream result checker; generalises the bench-side golden compare of the accelerator result stream into on-chip hardware.
- Sits on the result AXI-Stream output of the top level.
- Holds golden beats in an internal BRAM and applies a programmable tready backpressure pattern.
- Checks data, tkeep, tlast position and inactivity timeout, then reports a pass/fail summary per frame.

Parameters:
- DATA_WIDTH, 64, stream data width in bits (multiple of 8)
- FRAME_BEATS, 256, expected beats per frame
- GOLD_DEPTH, 512, golden memory depth in beats (must be >= FRAME_BEATS)
- ADDR_W, 9, golden address width (clog2 of GOLD_DEPTH)
- CNT_W, 16, width of error and beat counters
- TIMEOUT_CYCLES, 200000, idle cycles in RUN before timeout
- STALL_W, 8, length of the tready stall pattern

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- i_gold_we  in  1  golden write strobe
- i_gold_addr  in  ADDR_W  golden write address
- i_gold_wdata  in  DATA_WIDTH  golden write data
- i_arm  in  1  start checking one frame
- i_stall_mask  in  STALL_W  bit k=1 forces tready low in pattern phase k
- s_axis_tvalid  in  1  result beat valid
- s_axis_tready  out  1  checker ready
- s_axis_tdata  in  DATA_WIDTH  result data
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables
- s_axis_tlast  in  1  end of frame
- o_busy  out  1  high in RUN and FLUSH
- o_done  out  1  high in DONE
- o_pass  out  1  frame verdict, valid while o_done
- o_err_cnt  out  CNT_W  mismatching beats, saturating
- o_beat_cnt  out  CNT_W  accepted beats
- o_first_err_idx  out  CNT_W  index of first mismatching beat; all-ones if none
- o_tlast_err  out  1  tlast early, missing, or late
- o_timeout  out  1  inactivity timeout fired

Behaviour:
- Reset values: all outputs 0, except o_first_err_idx = all-ones. State IDLE, stall phase 0, idle counter 0.
- State machine:
  - IDLE: tready=0. Golden writes are accepted. i_arm moves to RUN and clears all counters and flags.
  - RUN: tready = ~i_stall_mask[phase]. Phase increments every cycle and wraps after STALL_W-1.
  - A handshake (tvalid & tready) latches data, tkeep and index into a compare stage, reads golden[o_beat_cnt], and increments o_beat_cnt (saturating).
- Compare stage: result appears 1 cycle after the handshake.
  - A mismatch increments o_err_cnt, saturating at all-ones.
  - o_first_err_idx is written only while it holds all-ones.
- Frame end:
  - Handshake with tlast at index FRAME_BEATS-1: go to FLUSH.
  - tlast at a smaller index: set o_tlast_err, go to FLUSH.
  - Index FRAME_BEATS-1 accepted without tlast: set o_tlast_err, go to FLUSH. Further beats are not accepted.
- Timeout: the idle counter counts RUN cycles with no handshake and resets on each handshake. Reaching TIMEOUT_CYCLES sets o_timeout and goes to FLUSH.
- FLUSH: exactly 1 cycle with tready=0 so the last compare retires; then go to DONE.
- DONE: o_done=1. o_pass = (err_cnt==0) & ~tlast_err & ~timeout & (beat_cnt==FRAME_BEATS). Outputs hold until i_arm, which re-arms directly to RUN.
- Priority on the same cycle:
  - A handshake on the cycle timeout would fire cancels the timeout.
  - i_arm in RUN or FLUSH is ignored.
  - i_gold_we while o_busy is ignored.
  - Golden write to an address >= GOLD_DEPTH is ignored.
- A stall mask of all-ones in RUN produces the timeout path. A mask change takes effect on the next cycle.
- Reset mid-frame: immediate return to reset values and tready=0. Golden memory contents are not cleared.

Optional Feature:
- Macro AXIS_FRAME_CHK_KEEP_MASK_EN.
- Defined: compare only bytes whose tkeep bit is 1; masked bytes never cause a mismatch.
- Undefined: full-width compare; any beat whose tkeep is not all-ones counts as a mismatch regardless of data.

Test Plan:
- Load golden[i]=i*0x0101010101010101 for i=0..255, arm, send a matching 256-beat frame with tlast on beat 255, mask 0 -> o_done, o_pass=1, o_err_cnt=0, o_beat_cnt=256, o_first_err_idx=0xFFFF.
- Same frame with beats 17 and 200 corrupted -> o_err_cnt=2, o_first_err_idx=17, o_pass=0.
- Mask 8'b1010_1010 with tvalid held high -> tready high on alternate cycles only, frame passes, about 512 cycles from arm to FLUSH.
- tlast on beat 99 -> o_tlast_err=1, o_beat_cnt=100, o_pass=0. A second frame with no tlast -> o_tlast_err=1, tready=0 after beat 255.
- TIMEOUT_CYCLES=50, send 10 beats then stop -> o_timeout=1 about 50 cycles after beat 9, o_beat_cnt=10. Repeat with rst_n pulsed mid-frame -> all outputs return to reset values.
- tkeep=0x0F with differing upper bytes on beat 5 -> macro defined: o_pass=1; macro undefined: o_err_cnt=1, o_first_err_idx=5.
